// File: rtl/simon_iter_core.sv
// simon_iter_core -- iterative Simon block-cipher datapath, one Feistel round
// per clock over a 2*WORD_W block {x, y}.
//
// Optional feature macro: SIMON_DEC_EN
//   defined   : mode_i (sampled with the block) selects encrypt (0) or
//               decrypt (1); decrypt walks the round keys in reverse order.
//   undefined : encrypt only, mode_i is ignored, rk_idx_o = round counter.
//
// Ports
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   in_valid_i    input block valid
//   in_ready_o    high only while idle; a block is taken on valid & ready
//   mode_i        0 = encrypt, 1 = decrypt (only with SIMON_DEC_EN)
//   pt_i          input block {x = [2W-1:W], y = [W-1:0]}
//   rk_idx_o      round-key index requested this cycle (0 outside a run)
//   rk_i          round key for rk_idx_o, valid combinationally same cycle
//   out_valid_o   result valid, held until out_ready_i
//   out_ready_i   consumer accepts result
//   ct_o          result block {x, y}, always the block register
module simon_iter_core #(
  parameter int WORD_W = 64,
  parameter int ROUNDS = 68,
  parameter int IDX_W  = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic                mode_i,
  input  logic [2*WORD_W-1:0] pt_i,
  output logic [IDX_W-1:0]    rk_idx_o,
  input  logic [WORD_W-1:0]   rk_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [2*WORD_W-1:0] ct_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

  state_t              state_r;
  state_t              state_nxt_s;
  logic [2*WORD_W-1:0] blk_r;
  logic [2*WORD_W-1:0] round_s;
  logic [IDX_W-1:0]    cnt_r;
  logic [WORD_W-1:0]   x_s;
  logic [WORD_W-1:0]   y_s;

  // Rotate left by n, modulo the word width.
  function automatic logic [WORD_W-1:0] rol(input logic [WORD_W-1:0] v, input int n);
    return (v << n) | (v >> (WORD_W - n));
  endfunction

  // Simon round function f(v) = (ROL1 & ROL8) ^ ROL2, pure bitwise.
  function automatic logic [WORD_W-1:0] simon_f(input logic [WORD_W-1:0] v);
    return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
  endfunction

  assign x_s  = blk_r[2*WORD_W-1:WORD_W];
  assign y_s  = blk_r[WORD_W-1:0];
  assign ct_o = blk_r;

`ifdef SIMON_DEC_EN
  logic mode_r;

  // Direction latched with the block so mode_i may change during a run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r <= 1'b0;
    end else if (state_r == ST_IDLE && in_valid_i) begin
      mode_r <= mode_i;
    end else begin
      mode_r <= mode_r;
    end
  end

  // One Feistel round, forward or inverse depending on the latched mode.
  always_comb begin
    if (mode_r) begin
      round_s = {y_s, x_s ^ simon_f(y_s) ^ rk_i};
    end else begin
      round_s = {y_s ^ simon_f(x_s) ^ rk_i, x_s};
    end
  end
`else
  // mode_i has no function in an encrypt-only build.
  logic unused_mode_s;
  assign unused_mode_s = mode_i;

  // One forward Feistel round.
  always_comb begin
    round_s = {y_s ^ simon_f(x_s) ^ rk_i, x_s};
  end
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; DONE always returns through IDLE (one bubble cycle).
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid_i) state_nxt_s = ST_RUN;
        else            state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (cnt_r == LAST_IDX) state_nxt_s = ST_DONE;
        else                   state_nxt_s = ST_RUN;
      end
      ST_DONE: begin
        if (out_ready_i) state_nxt_s = ST_IDLE;
        else             state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Block register and round counter; counter parks at 0 after the last round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_r <= {(2*WORD_W){1'b0}};
      cnt_r <= {IDX_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid_i) begin
            blk_r <= pt_i;
            cnt_r <= {IDX_W{1'b0}};
          end else begin
            blk_r <= blk_r;
            cnt_r <= cnt_r;
          end
        end
        ST_RUN: begin
          blk_r <= round_s;
          if (cnt_r == LAST_IDX) cnt_r <= {IDX_W{1'b0}};
          else                   cnt_r <= cnt_r + IDX_W'(1);
        end
        default: begin
          blk_r <= blk_r;
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Output decode from the state register.
  always_comb begin
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    rk_idx_o    = {IDX_W{1'b0}};
    case (state_r)
      ST_IDLE: in_ready_o = 1'b1;
      ST_RUN: begin
`ifdef SIMON_DEC_EN
        if (mode_r) rk_idx_o = LAST_IDX - cnt_r;
        else        rk_idx_o = cnt_r;
`else
        rk_idx_o = cnt_r;
`endif
      end
      ST_DONE: out_valid_o = 1'b1;
      default: begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_simon_iter_core.sv
`timescale 1ns/1ps
module tb_simon_iter_core;

`ifdef SIMON_DEC_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;

  typedef logic [63:0] ks_t [68];

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Instance A: Simon128/128 (64-bit words, 68 rounds)
  logic a_in_valid, a_in_ready, a_mode, a_out_valid, a_out_ready;
  logic [127:0] a_pt, a_ct;
  logic [6:0] a_idx;
  logic [63:0] a_rk;
  // Instance B: Simon64/128 (32-bit words, 44 rounds)
  logic b_in_valid, b_in_ready, b_mode, b_out_valid, b_out_ready;
  logic [63:0] b_pt, b_ct;
  logic [5:0] b_idx;
  logic [31:0] b_rk;
  // Instance C: single round, 64-bit words
  logic c_in_valid, c_in_ready, c_mode, c_out_valid, c_out_ready;
  logic [127:0] c_pt, c_ct;
  logic [0:0] c_idx;
  logic [63:0] c_rk;

  ks_t ks_w, ks_a, ks_b, ks_c;

  assign a_rk = ks_a[a_idx];
  assign b_rk = ks_b[b_idx][31:0];

  simon_iter_core #(.WORD_W(64), .ROUNDS(68)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
    .mode_i(a_mode), .pt_i(a_pt), .rk_idx_o(a_idx), .rk_i(a_rk),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .ct_o(a_ct));

  simon_iter_core #(.WORD_W(32), .ROUNDS(44)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
    .mode_i(b_mode), .pt_i(b_pt), .rk_idx_o(b_idx), .rk_i(b_rk),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .ct_o(b_ct));

  simon_iter_core #(.WORD_W(64), .ROUNDS(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid_i(c_in_valid), .in_ready_o(c_in_ready),
    .mode_i(c_mode), .pt_i(c_pt), .rk_idx_o(c_idx), .rk_i(c_rk),
    .out_valid_o(c_out_valid), .out_ready_i(c_out_ready), .ct_o(c_ct));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model (plain Simon arithmetic) ----------------
  function automatic logic [63:0] mask_w(input int w);
    return (w == 64) ? 64'hffff_ffff_ffff_ffff : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] rol_m(input logic [63:0] v, input int n, input int w);
    return ((v << n) | (v >> (w - n))) & mask_w(w);
  endfunction

  function automatic logic [63:0] f_m(input logic [63:0] v, input int w);
    return (rol_m(v, 1, w) & rol_m(v, 8, w)) ^ rol_m(v, 2, w);
  endfunction

  // Standard Simon key schedule, m key words, w-bit words, t rounds.
  task automatic expand(input logic [63:0] k0, input logic [63:0] k1, input logic [63:0] k2,
                        input logic [63:0] k3, input int m, input int w, input int t,
                        input logic [61:0] z);
    logic [63:0] tmp;
    for (int i = 0; i < 68; i++) ks_w[i] = 64'd0;
    ks_w[0] = k0; ks_w[1] = k1; ks_w[2] = k2; ks_w[3] = k3;
    for (int i = m; i < t; i++) begin
      tmp = rol_m(ks_w[i-1], w - 3, w);
      if (m == 4) tmp = tmp ^ ks_w[i-3];
      tmp = tmp ^ rol_m(tmp, w - 1, w);
      ks_w[i] = (~ks_w[i-m] & mask_w(w)) ^ tmp ^ 64'(z[61 - ((i - m) % 62)]) ^ 64'd3;
    end
  endtask

  // Returns {x, y} as two 64-bit halves; decrypt only when the build has it.
  function automatic logic [127:0] model(input logic [63:0] x0, input logic [63:0] y0, input bit dec,
                                         input int w, input int r, input ks_t ks);
    logic [63:0] x, y, t;
    x = x0; y = y0;
    if (dec && DEC_EN) begin
      for (int i = r - 1; i >= 0; i--) begin
        t = y; y = x ^ f_m(y, w) ^ ks[i]; x = t;
      end
    end else begin
      for (int i = 0; i < r; i++) begin
        t = x; x = y ^ f_m(x, w) ^ ks[i]; y = t;
      end
    end
    return {x, y};
  endfunction

  // ---------------- instance A driver ----------------
  task automatic accept_a(input bit mode, input logic [127:0] pt, input string name);
    int t = 0;
    while (a_in_ready !== 1'b1 && t < 200) begin
      @(posedge clk); #1; t++;
    end
    check({name, "/in_ready_wait"}, a_in_ready, 1);
    a_in_valid = 1'b1; a_mode = mode; a_pt = pt;
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_mode = ~mode; a_pt = ~pt;
  endtask

  task automatic run_a(input bit mode, input logic [127:0] pt, input logic [127:0] exp,
                       input bit noise, input int hold, input string name);
    bit idx_ok = 1'b1, low_ok = 1'b1, stable_ok = 1'b1;
    accept_a(mode, pt, name);
    for (int c = 0; c < 68; c++) begin
      int exp_idx = (mode && DEC_EN) ? (67 - c) : c;
      if (a_idx !== 7'(exp_idx)) idx_ok = 1'b0;
      if (a_out_valid !== 1'b0 || a_in_ready !== 1'b0) low_ok = 1'b0;
      a_in_valid  = noise && c >= 3 && c < 6;
      a_out_ready = noise && c < 67;
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0; a_out_ready = 1'b0;
    check({name, "/rk_idx_seq"}, idx_ok, 1);
    check({name, "/busy_flags"}, low_ok, 1);
    check({name, "/out_valid"}, a_out_valid, 1);
    check({name, "/ct"}, a_ct, exp);
    check({name, "/idx_done"}, a_idx, 0);
    for (int h = 0; h < hold; h++) begin
      a_in_valid = (h == 2); a_pt = ~pt;
      @(posedge clk); #1;
      if (a_ct !== exp || a_out_valid !== 1'b1 || a_in_ready !== 1'b0) stable_ok = 1'b0;
    end
    a_in_valid = 1'b0;
    if (hold > 0) check({name, "/hold_stable"}, stable_ok, 1);
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    check({name, "/released_valid"}, a_out_valid, 0);
    check({name, "/released_ready"}, a_in_ready, 1);
    @(posedge clk); #1;
    check({name, "/still_idle"}, {a_in_ready, a_out_valid}, 2'b10);
  endtask

  task automatic reset_check(input string name);
    check({name, "/rst_out_valid"}, a_out_valid, 0);
    check({name, "/rst_ct"}, a_ct, 0);
    check({name, "/rst_in_ready"}, a_in_ready, 1);
    check({name, "/rst_idx"}, a_idx, 0);
  endtask

  // ---------------- instance B / C drivers ----------------
  task automatic run_b(input bit mode, input logic [63:0] pt, input logic [63:0] exp, input string name);
    b_in_valid = 1'b1; b_mode = mode; b_pt = pt;
    @(posedge clk); #1;
    b_in_valid = 1'b0; b_pt = ~pt;
    repeat (43) @(posedge clk);
    #1 check({name, "/early"}, b_out_valid, 0);
    @(posedge clk); #1;
    check({name, "/out_valid"}, b_out_valid, 1);
    check({name, "/ct"}, b_ct, exp);
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    check({name, "/back_idle"}, b_in_ready, 1);
  endtask

  task automatic run_c(input bit mode, input logic [127:0] pt, input logic [127:0] exp, input string name);
    c_in_valid = 1'b1; c_mode = mode; c_pt = pt;
    @(posedge clk); #1;
    c_in_valid = 1'b0;
    check({name, "/run_state"}, {c_idx, c_out_valid, c_in_ready}, 3'b000);
    @(posedge clk); #1;
    check({name, "/out_valid"}, c_out_valid, 1);
    check({name, "/ct"}, c_ct, exp);
    c_out_ready = 1'b1;
    @(posedge clk); #1;
    c_out_ready = 1'b0;
    check({name, "/back_idle"}, c_in_ready, 1);
  endtask

  typedef struct {
    bit           mode;
    logic [127:0] pt;
    logic [127:0] exp;
    bit           noise;
    int           hold;
  } vec_t;

  localparam logic [127:0] KAT_PT = 128'h63736564207372656c6c657661727420;
  localparam logic [127:0] KAT_CT = 128'h49681b1e1e54fe3f65aa832af84e0bbc;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    logic [127:0] r128, e128;
    logic [63:0] r64;
    bit m;

    rst_n = 1'b0;
    {a_in_valid, a_mode, a_out_ready, b_in_valid, b_mode, b_out_ready} = 6'd0;
    {c_in_valid, c_mode, c_out_ready} = 3'd0;
    a_pt = 128'd0; b_pt = 64'd0; c_pt = 128'd0; c_rk = 64'd0;

    expand(64'h0706050403020100, 64'h0f0e0d0c0b0a0908, 64'd0, 64'd0, 2, 64, 68, Z2);
    ks_a = ks_w;
    expand(64'h03020100, 64'h0b0a0908, 64'h13121110, 64'h1b1a1918, 4, 32, 44, Z3);
    ks_b = ks_w;
    for (int i = 0; i < 68; i++) ks_c[i] = 64'd0;

    // Vector table: known answers first, then random blocks and modes.
    vecs[0] = '{1'b0, KAT_PT, KAT_CT, 1'b0, 0};
    vecs[1] = '{1'b1, KAT_CT, DEC_EN ? KAT_PT : model(KAT_CT[127:64], KAT_CT[63:0], 1'b0, 64, 68, ks_a), 1'b0, 0};
    vecs[2] = '{1'b0, KAT_PT, KAT_CT, 1'b1, 5};
    for (int i = 3; i < 10; i++) begin
      r128 = {$urandom, $urandom, $urandom, $urandom};
      m = 1'($urandom_range(0, 1));
      vecs[i] = '{m, r128, model(r128[127:64], r128[63:0], m, 64, 68, ks_a), 1'(i % 2), (i == 6) ? 3 : 0};
    end

    repeat (2) @(posedge clk);
    #1 reset_check("reset");
    check("reset/c_idle", {c_in_ready, c_out_valid, c_ct}, {2'b10, 128'd0});
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_a(vecs[i].mode, vecs[i].pt, vecs[i].exp, vecs[i].noise, vecs[i].hold,
                                       $sformatf("vec%0d", i));

    // Abort at run cycle 30, then a fresh block.
    accept_a(1'b0, KAT_PT, "abort_run");
    repeat (30) @(posedge clk);
    #1 check("abort_run/idx30", a_idx, 30);
    #2 rst_n = 1'b0;
    #1 reset_check("abort_run");
    @(posedge clk); #1 rst_n = 1'b1;
    run_a(1'b0, KAT_PT, KAT_CT, 1'b0, 0, "after_abort_run");

    // Abort while a result waits in DONE.
    accept_a(1'b0, KAT_PT, "abort_done");
    repeat (70) @(posedge clk);
    #1 check("abort_done/waiting", {a_out_valid, a_ct}, {1'b1, KAT_CT});
    #2 rst_n = 1'b0;
    #1 reset_check("abort_done");
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Simon64/128 known answer plus a random block.
    run_b(1'b0, 64'h656b696c20646e75, 64'h44c8fc20b9dfa07a, "simon64_kat");
    r64 = {$urandom, $urandom};
    m = 1'($urandom_range(0, 1));
    e128 = model({32'd0, r64[63:32]}, {32'd0, r64[31:0]}, m, 32, 44, ks_b);
    run_b(m, r64, {e128[95:64], e128[31:0]}, "simon64_rand");

    // Single-round core: spec vector, then random keys and modes.
    c_rk = 64'd0;
    run_c(1'b0, {64'h1, 64'h0}, {64'h4, 64'h1}, "one_round");
    for (int i = 0; i < 4; i++) begin
      r128 = {$urandom, $urandom, $urandom, $urandom};
      c_rk = {$urandom, $urandom};
      ks_c[0] = c_rk;
      m = 1'($urandom_range(0, 1));
      run_c(m, r128, model(r128[127:64], r128[63:0], m, 64, 1, ks_c), $sformatf("one_round_rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
